cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/cache_arbiter.sv | 135 +++++++++++++
 tb/tb_cache_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// Two-requester round-robin arbiter in front of a single-ported cache.
// Each granted request runs IDLE -> BUSY -> RELEASE, ending in a done pulse (with an optional timeout error).
module cache_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [24:0] req0,
  input  logic [24:0] req1,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic [7:0]  resp0_data,
  output logic [7:0]  resp1_data,
  output logic        resp0_done,
  output logic        resp1_done,
  output logic        resp_error,
  output logic [24:0] cache_request,
  output logic        cache_request_ready,
  input  logic [7:0]  cache_data_out,
  input  logic        cache_data_out_ready,
  output logic        grant,
  output logic        busy
);

  // Counter value at which the next silent BUSY edge aborts the transaction.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [24:0] req_reg, req_next;
  logic        grant_reg, grant_next;
  logic        prio_reg, prio_next;
  logic [7:0]  count_reg, count_next;
  logic        error_reg;
  logic        winner;
  logic        finish_ok;
  logic        finish_timeout;

  always_comb begin
    state_next     = state_reg;
    req_next       = req_reg;
    grant_next     = grant_reg;
    prio_next      = prio_reg;
    count_next     = count_reg;
    winner         = 1'b0;
    finish_ok      = 1'b0;
    finish_timeout = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          // prio_reg names the requester that wins a tie; a lone requester always wins
          winner     = (req0_valid && req1_valid) ? prio_reg : req1_valid;
          req_next   = winner ? req1 : req0;
          grant_next = winner;
          prio_next  = ~winner;
          count_next = '0;
          state_next = BUSY;
        end
      end
      BUSY: begin
        // A response arriving on the limit edge still counts as a normal completion
        if (cache_data_out_ready) begin
          finish_ok  = 1'b1;
          state_next = RELEASE;
        end else if (count_reg == TIMEOUT_LAST) begin
          finish_timeout = 1'b1;
          state_next     = RELEASE;
        end else begin
          count_next = count_reg + 8'd1;
        end
      end
      RELEASE: begin
        if (!cache_data_out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      req_reg   <= '0;
      grant_reg <= 1'b0;
      prio_reg  <= 1'b0;
      count_reg <= '0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      req_reg   <= req_next;
      grant_reg <= grant_next;
      prio_reg  <= prio_next;
      count_reg <= count_next;
      error_reg <= finish_timeout;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_resp
      localparam logic IDX = 1'(gi);
      logic [7:0] data_reg;
      logic       done_reg;

      always_ff @(posedge clock) begin
        if (reset) begin
          data_reg <= '0;
          done_reg <= 1'b0;
        end else begin
          done_reg <= (finish_ok || finish_timeout) && (grant_reg == IDX);
          if (finish_ok && (grant_reg == IDX)) begin
            data_reg <= cache_data_out;
          end
        end
      end
    end
  endgenerate

  assign resp0_data          = g_resp[0].data_reg;
  assign resp1_data          = g_resp[1].data_reg;
  assign resp0_done          = g_resp[0].done_reg;
  assign resp1_done          = g_resp[1].done_reg;
  assign resp_error          = error_reg;
  assign cache_request       = (state_reg == BUSY) ? req_reg : '0;
  assign cache_request_ready = (state_reg == BUSY);
  assign grant               = grant_reg;
  assign busy                = (state_reg != IDLE);

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: vector table of single transactions, hand sequences for
// arbitration order and reset abort, then a randomized soak against a transaction-level model.
module tb_cache_arbiter;

  localparam int TMO = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [24:0] req0 = '0;
  logic [24:0] req1 = '0;
  logic        req0_valid = 1'b0;
  logic        req1_valid = 1'b0;
  logic [7:0]  resp0_data, resp1_data;
  logic        resp0_done, resp1_done, resp_error;
  logic [24:0] cache_request;
  logic        cache_request_ready;
  logic [7:0]  cache_data_out = '0;
  logic        cache_data_out_ready = 1'b0;
  logic        grant, busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] model_data [2];

  cache_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock               (clock),
    .reset               (reset),
    .req0                (req0),
    .req1                (req1),
    .req0_valid          (req0_valid),
    .req1_valid          (req1_valid),
    .resp0_data          (resp0_data),
    .resp1_data          (resp1_data),
    .resp0_done          (resp0_done),
    .resp1_done          (resp1_done),
    .resp_error          (resp_error),
    .cache_request       (cache_request),
    .cache_request_ready (cache_request_ready),
    .cache_data_out      (cache_data_out),
    .cache_data_out_ready(cache_data_out_ready),
    .grant               (grant),
    .busy                (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    int          r;
    logic [24:0] rq;
    int          k;        // BUSY cycle in which the cache answers (0 = never)
    logic [7:0]  cd;
    int          hold;     // extra cycles cache_data_out_ready stays high after the answer
    logic        raise;    // raise the other requester during RELEASE
    logic [24:0] orq;
    logic [7:0]  exp_data;
    logic        exp_err;
    int          exp_busy;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic done_of(input int r);
    return (r == 1) ? resp1_done : resp0_done;
  endfunction

  function automatic logic [7:0] data_of(input int r);
    return (r == 1) ? resp1_data : resp0_data;
  endfunction

  task automatic set_req(input int r, input logic v, input logic [24:0] rq);
    if (r == 1) begin
      req1 = rq;
      req1_valid = v;
    end else begin
      req0 = rq;
      req0_valid = v;
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_cache_request"}, 32'(cache_request), 32'd0);
    check({name, "_cache_ready"}, 32'(cache_request_ready), 32'd0);
    check({name, "_resp0_data"}, 32'(resp0_data), 32'd0);
    check({name, "_resp1_data"}, 32'(resp1_data), 32'd0);
    check({name, "_resp0_done"}, 32'(resp0_done), 32'd0);
    check({name, "_resp1_done"}, 32'(resp1_done), 32'd0);
    check({name, "_resp_error"}, 32'(resp_error), 32'd0);
    check({name, "_grant"}, 32'(grant), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_txn(input string name, input int r, input logic [24:0] rq, input int k,
                         input logic [7:0] cd, input int hold, input logic raise,
                         input logic [24:0] orq, input logic [7:0] exp_data,
                         input logic exp_err, input int exp_busy);
    int n;
    int c;
    int o;
    o = 1 - r;
    set_req(r, 1'b1, rq);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!cache_request_ready && n < 20);
    check({name, "_granted"}, 32'(cache_request_ready), 32'd1);
    check({name, "_grant"}, 32'(grant), 32'(r));
    check({name, "_request"}, 32'(cache_request), 32'(rq));
    c = 0;
    while (cache_request_ready && c < 50) begin
      c++;
      cache_data_out_ready = (c == k);
      cache_data_out = cd;
      @(negedge clock);
    end
    check({name, "_busy_cycles"}, 32'(c), 32'(exp_busy));
    check({name, "_done"}, 32'(done_of(r)), 32'd1);
    check({name, "_other_done"}, 32'(done_of(o)), 32'd0);
    check({name, "_error"}, 32'(resp_error), 32'(exp_err));
    check({name, "_data"}, 32'(data_of(r)), 32'(exp_data));
    check({name, "_other_data"}, 32'(data_of(o)), 32'(model_data[o]));
    model_data[r] = exp_data;
    $display("txn %s: requester=%0d data=%0h error=%0b busy_cycles=%0d",
             name, r, data_of(r), resp_error, c);
    set_req(r, 1'b0, rq);
    if (raise) set_req(o, 1'b1, orq);
    cache_data_out_ready = (hold > 0);
    for (int h = 1; h <= hold; h++) begin
      @(negedge clock);
      check({name, "_release_busy"}, 32'(busy), 32'd1);
      check({name, "_release_ready"}, 32'(cache_request_ready), 32'd0);
      check({name, "_release_request"}, 32'(cache_request), 32'd0);
      check({name, "_release_quiet"}, 32'({resp0_done, resp1_done, resp_error}), 32'd0);
      cache_data_out_ready = (h < hold);
    end
    @(negedge clock);
    check({name, "_idle"}, 32'(busy), 32'd0);
    check({name, "_idle_quiet"}, 32'({resp0_done, resp1_done, resp_error}), 32'd0);
  endtask

  task automatic soak(input int ntx);
    logic        pend [2];
    logic [24:0] rqv [2];
    logic [7:0]  mem [16];
    logic [7:0]  exp_dat [2];
    int          waits [2];
    logic        served_now [2];
    int prefer = 0;
    int cur = 0;
    int c = 0;
    int k = 0;
    int hold_left = 0;
    int exp_r = 0;
    int win = 0;
    int served = 0;
    int cycles = 0;
    logic prev_rdy = 1'b0;
    logic exp_done = 1'b0;
    logic exp_err = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0;
      rqv[i] = '0;
      exp_dat[i] = '0;
      waits[i] = 0;
    end
    while (served < ntx && cycles < 60000) begin
      @(negedge clock);
      cycles++;
      served_now[0] = 1'b0;
      served_now[1] = 1'b0;
      if (exp_done) begin
        check("soak_done", 32'(done_of(exp_r)), 32'd1);
        check("soak_other_done", 32'(done_of(1 - exp_r)), 32'd0);
        check("soak_error", 32'(resp_error), 32'(exp_err));
        check("soak_data0", 32'(resp0_data), 32'(exp_dat[0]));
        check("soak_data1", 32'(resp1_data), 32'(exp_dat[1]));
        $display("txn soak%0d: requester=%0d data=%0h error=%0b", served, exp_r,
                 data_of(exp_r), resp_error);
        pend[exp_r] = 1'b0;
        served_now[exp_r] = 1'b1;
        served++;
        exp_done = 1'b0;
      end else begin
        check("soak_quiet", 32'({resp0_done, resp1_done, resp_error}), 32'd0);
      end
      if (cache_request_ready && !prev_rdy) begin
        win = (pend[0] && pend[1]) ? prefer : (pend[1] ? 1 : 0);
        check("soak_pending", 32'(pend[0] | pend[1]), 32'd1);
        check("soak_grant", 32'(grant), 32'(win));
        check("soak_request", 32'(cache_request), 32'(rqv[win]));
        if (pend[1 - win]) waits[1 - win]++;
        check("soak_starve", 32'(waits[1 - win] <= 1), 32'd1);
        waits[win] = 0;
        prefer = 1 - win;
        cur = win;
        c = 0;
        k = $urandom_range(1, 6);
      end
      prev_rdy = cache_request_ready;
      if (cache_request_ready) begin
        c++;
        if (c == k) begin
          if (rqv[cur][24]) mem[rqv[cur][3:0]] = rqv[cur][23:16];
          cache_data_out = mem[rqv[cur][3:0]];
          cache_data_out_ready = 1'b1;
          exp_done = 1'b1;
          exp_r = cur;
          exp_err = 1'b0;
          exp_dat[cur] = mem[rqv[cur][3:0]];
          hold_left = $urandom_range(0, 2);
        end else begin
          cache_data_out = 8'($urandom);
          cache_data_out_ready = 1'b0;
          if (c == TMO) begin
            exp_done = 1'b1;
            exp_r = cur;
            exp_err = 1'b1;
            hold_left = 0;
          end
        end
      end else begin
        cache_data_out_ready = (hold_left > 0);
        if (hold_left > 0) hold_left--;
      end
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && !served_now[r] && $urandom_range(0, 2) == 0) begin
          pend[r] = 1'b1;
          rqv[r] = {1'($urandom), 8'($urandom), 16'($urandom)};
        end
      end
      set_req(0, pend[0], rqv[0]);
      set_req(1, pend[1], rqv[1]);
    end
    check("soak_complete", 32'(served >= ntx), 32'd1);
  endtask

  initial begin
    model_data[0] = '0;
    model_data[1] = '0;
    vecs[0] = '{"r0_write55", 0, {1'b1, 8'd55, 16'd12}, 3, 8'd55, 0, 1'b0, 25'd0, 8'd55, 1'b0, 3};
    vecs[1] = '{"r1_read_fast", 1, {1'b0, 8'd0, 16'd13}, 1, 8'hA5, 1, 1'b0, 25'd0, 8'hA5, 1'b0, 1};
    vecs[2] = '{"r0_limit_edge", 0, {1'b0, 8'd0, 16'h0100}, 4, 8'h3C, 2, 1'b0, 25'd0, 8'h3C, 1'b0, 4};
    vecs[3] = '{"r1_timeout", 1, {1'b1, 8'h77, 16'h8000}, 0, 8'hEE, 0, 1'b0, 25'd0, 8'hA5, 1'b1, 4};
    vecs[4] = '{"r0_timeout", 0, {1'b0, 8'd0, 16'h0200}, 6, 8'hDD, 0, 1'b0, 25'd0, 8'h3C, 1'b1, 4};
    vecs[5] = '{"r1_long_release", 1, {1'b0, 8'd0, 16'h0001}, 2, 8'hC3, 3, 1'b1,
                {1'b0, 8'd0, 16'h0042}, 8'hC3, 1'b0, 2};
    vecs[6] = '{"r0_after_release", 0, {1'b0, 8'd0, 16'h0042}, 1, 8'h99, 0, 1'b0, 25'd0,
                8'h99, 1'b0, 1};

    repeat (2) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;

    // Simultaneous requests straight out of reset: 0 first, then the tie goes to 1
    set_req(0, 1'b1, {1'b0, 8'd0, 16'd13});
    set_req(1, 1'b1, {1'b0, 8'd0, 16'd14});
    run_txn("pair_r0_first", 0, {1'b0, 8'd0, 16'd13}, 2, 8'h11, 0, 1'b0, 25'd0, 8'h11, 1'b0, 2);
    set_req(0, 1'b1, {1'b0, 8'd0, 16'd15});
    run_txn("pair_r1_next", 1, {1'b0, 8'd0, 16'd14}, 1, 8'h22, 0, 1'b0, 25'd0, 8'h22, 1'b0, 1);
    run_txn("pair_r0_last", 0, {1'b0, 8'd0, 16'd15}, 3, 8'h33, 0, 1'b0, 25'd0, 8'h33, 1'b0, 3);

    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i].name, vecs[i].r, vecs[i].rq, vecs[i].k, vecs[i].cd, vecs[i].hold,
              vecs[i].raise, vecs[i].orq, vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_busy);
    end

    // Reset two cycles into BUSY aborts silently
    set_req(1, 1'b1, {1'b0, 8'd0, 16'd500});
    @(negedge clock);
    check("abort_granted", 32'(cache_request_ready), 32'd1);
    check("abort_grant", 32'(grant), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_reset_outputs("abort_reset");
    reset = 1'b0;
    set_req(1, 1'b0, {1'b0, 8'd0, 16'd500});
    model_data[0] = '0;
    model_data[1] = '0;
    repeat (3) begin
      @(negedge clock);
      check("abort_no_done", 32'({resp0_done, resp1_done, busy}), 32'd0);
    end
    run_txn("r1_read_ffff", 1, {1'b0, 8'd0, 16'hFFFF}, 2, 8'h5A, 0, 1'b0, 25'd0, 8'h5A, 1'b0, 2);

    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    soak(3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
